// File: rtl/down_counter_timer_pkg.sv
// Shared definitions for the loadable down-counter/timer.
// Holds the default counter width and the 1-bit IDLE/RUN state encoding.
package down_counter_timer_pkg;

  localparam int unsigned DEFAULT_WIDTH = 4;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_e;

endpackage : down_counter_timer_pkg

// File: rtl/down_counter_timer.sv
// Loadable down-counter/timer with a valid/ready load port and a one-cycle
// done pulse on terminal count.
//
// Ports:
//   clk        : clock, rising edge
//   rstn       : synchronous active-low reset
//   clear      : synchronous abort to IDLE (below rstn, above everything else)
//   load_valid : load request
//   load_value : start value, taken when load_valid & load_ready
//   load_ready : high in IDLE (decoded from state)
//   en         : count enable
//   out        : current count (registered)
//   busy       : high in RUN (decoded from state)
//   done       : one-cycle terminal-count pulse (registered)
//
// Optional build macro DOWN_COUNTER_TIMER_RELOAD_EN: periodic mode. The last
// accepted load value is kept and re-armed at every terminal count, so the
// timer stays in RUN until clear or reset.
module down_counter_timer
  import down_counter_timer_pkg::*;
#(
  parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             clear,
  input  logic             load_valid,
  input  logic [WIDTH-1:0] load_value,
  output logic             load_ready,
  input  logic             en,
  output logic [WIDTH-1:0] out,
  output logic             busy,
  output logic             done
);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] cnt_q, cnt_d;
  logic             done_q, done_d;
  logic             load_acc;

  assign load_acc = (state_q == ST_IDLE) && load_valid;

`ifdef DOWN_COUNTER_TIMER_RELOAD_EN
  logic [WIDTH-1:0] reload_q, reload_d;

  // Reload register: follows every accepted load; clear blocks acceptance
  always_comb begin
    reload_d = reload_q;
    if (!clear && load_acc) begin
      reload_d = load_value;
    end
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      reload_q <= '0;
    end else begin
      reload_q <= reload_d;
    end
  end
`endif

  // State register
  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Counter and done-pulse registers
  always_ff @(posedge clk) begin
    if (!rstn) begin
      cnt_q  <= '0;
      done_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      done_q <= done_d;
    end
  end

  // Next-state and datapath; done defaults low so it only ever pulses
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    done_d  = 1'b0;
    if (clear) begin
      state_d = ST_IDLE;
      cnt_d   = '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (load_acc) begin
            cnt_d = load_value;
            if (load_value != '0) begin
              state_d = ST_RUN;
            end else begin
              // Zero-length timer: terminal count immediately, never busy
              done_d = 1'b1;
            end
          end
        end
        ST_RUN: begin
          if (en) begin
            if (cnt_q > WIDTH'(1)) begin
              cnt_d = cnt_q - WIDTH'(1);
            end else if (cnt_q == WIDTH'(1)) begin
              done_d = 1'b1;
`ifdef DOWN_COUNTER_TIMER_RELOAD_EN
              cnt_d   = reload_q;
`else
              cnt_d   = '0;
              state_d = ST_IDLE;
`endif
            end
            // cnt_q == 0 in RUN is unreachable; hold rather than wrap
          end
        end
        default: begin
          state_d = ST_IDLE;
          cnt_d   = '0;
        end
      endcase
    end
  end

  // State-decoded handshake/status outputs
  always_comb begin
    load_ready = 1'b0;
    busy       = 1'b0;
    case (state_q)
      ST_IDLE: load_ready = 1'b1;
      ST_RUN:  busy       = 1'b1;
      default: load_ready = 1'b1;
    endcase
  end

  assign out  = cnt_q;
  assign done = done_q;

endmodule : down_counter_timer

// File: tb/tb_down_counter_timer.sv
// Self-checking bench for down_counter_timer (WIDTH=4): directed vector
// tables, a hand-written clear/ignore sequence, then randomized stimulus
// compared against a behavioural timer model.
module tb_down_counter_timer;

  localparam int unsigned W = 4;

  logic         clk = 1'b0;
  logic         rstn, clear, load_valid, en;
  logic [W-1:0] load_value;
  logic         load_ready, busy, done;
  logic [W-1:0] out_w;

  int checks = 0;
  int errors = 0;

  down_counter_timer #(.WIDTH(W)) dut (
    .clk        (clk),
    .rstn       (rstn),
    .clear      (clear),
    .load_valid (load_valid),
    .load_value (load_value),
    .load_ready (load_ready),
    .en         (en),
    .out        (out_w),
    .busy       (busy),
    .done       (done)
  );

  always #5 clk = ~clk;

  // Behavioural model: a timer is either idle or has "remaining" ticks left.
  bit m_running = 1'b0;
  int m_remaining = 0;
  bit m_done = 1'b0;
  int m_period = 0;
`ifdef DOWN_COUNTER_TIMER_RELOAD_EN
  localparam bit PERIODIC = 1'b1;
`else
  localparam bit PERIODIC = 1'b0;
`endif

  function automatic void model_tick(bit r, bit c, bit lv, int val, bit e);
    bit fired;
    fired = 1'b0;
    if (!r) begin
      m_running = 0; m_remaining = 0; m_period = 0;
    end else if (c) begin
      m_running = 0; m_remaining = 0;
    end else if (!m_running) begin
      if (lv) begin
        m_period    = val;
        m_remaining = val;
        m_running   = (val != 0);
        fired       = (val == 0);
      end
    end else if (e && m_remaining > 0) begin
      m_remaining = m_remaining - 1;
      if (m_remaining == 0) begin
        fired = 1'b1;
        if (PERIODIC) m_remaining = m_period;
        else m_running = 0;
      end
    end
    m_done = fired;
  endfunction

  task automatic check(string name, int got, int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, got, exp, $time);
    end
  endtask

  // Apply current inputs across one rising edge, update model, compare.
  task automatic step();
    model_tick(rstn, clear, load_valid, int'(load_value), en);
    @(posedge clk);
    #1;
    check("model_out",   int'(out_w), m_remaining);
    check("model_done",  int'(done), int'(m_done));
    check("model_busy",  int'(busy), int'(m_running));
    check("model_ready", int'(load_ready), int'(!m_running));
  endtask

  typedef struct {
    bit         rstn;
    bit         clear;
    bit         lv;
    logic [W-1:0] val;
    bit         en;
    int         exp_out;
    bit         exp_done;
    bit         exp_busy;
  } vec_t;

  vec_t vecs[$];

  function automatic void add(bit r, bit c, bit lv, int val, bit e,
                              int eo, bit ed, bit eb);
    vec_t v;
    v.rstn = r; v.clear = c; v.lv = lv; v.val = W'(val); v.en = e;
    v.exp_out = eo; v.exp_done = ed; v.exp_busy = eb;
    vecs.push_back(v);
  endfunction

  initial begin
    int done_cnt;
    rstn = 1'b0; clear = 1'b0; load_valid = 1'b0; load_value = '0; en = 1'b0;
    #1;

    // Reset for two cycles
    add(0,0,0,0,0, 0,0,0);
    add(0,0,0,0,0, 0,0,0);
    // Zero-length load: done next cycle, never busy
    add(1,0,1,0,1, 0,1,0);
    add(1,0,0,0,1, 0,0,0);
`ifdef DOWN_COUNTER_TIMER_RELOAD_EN
    // Periodic: load 2, en high -> 2,1,2,1,2,1 with done on each re-arm
    add(1,0,1,2,1, 2,0,1);
    add(1,0,0,0,1, 1,0,1);
    add(1,0,0,0,1, 2,1,1);
    add(1,0,0,0,1, 1,0,1);
    add(1,0,0,0,1, 2,1,1);
    add(1,0,0,0,1, 1,0,1);
    add(1,1,0,0,1, 0,0,0);
    add(1,0,0,0,0, 0,0,0);
`else
    // Load 5 with en high: 5,4,3,2,1,0 and one done with out=0
    add(1,0,1,5,1, 5,0,1);
    add(1,0,0,0,1, 4,0,1);
    add(1,0,0,0,1, 3,0,1);
    add(1,0,0,0,1, 2,0,1);
    add(1,0,0,0,1, 1,0,1);
    add(1,0,0,0,1, 0,1,0);
    add(1,0,0,0,1, 0,0,0);
    // Load 3 with en pattern 1,0,0,1,1
    add(1,0,1,3,0, 3,0,1);
    add(1,0,0,0,1, 2,0,1);
    add(1,0,0,0,0, 2,0,1);
    add(1,0,0,0,0, 2,0,1);
    add(1,0,0,0,1, 1,0,1);
    add(1,0,0,0,1, 0,1,0);
    add(1,0,0,0,0, 0,0,0);
    // Full-scale load 15 counts down fully
    add(1,0,1,15,1, 15,0,1);
    for (int k = 14; k >= 1; k--) add(1,0,0,0,1, k,0,1);
    add(1,0,0,0,1, 0,1,0);
`endif

    foreach (vecs[i]) begin
      rstn = vecs[i].rstn; clear = vecs[i].clear; load_valid = vecs[i].lv;
      load_value = vecs[i].val; en = vecs[i].en;
      step();
      check($sformatf("vec%0d_out", i),   int'(out_w), vecs[i].exp_out);
      check($sformatf("vec%0d_done", i),  int'(done), int'(vecs[i].exp_done));
      check($sformatf("vec%0d_busy", i),  int'(busy), int'(vecs[i].exp_busy));
      check($sformatf("vec%0d_ready", i), int'(load_ready), int'(!vecs[i].exp_busy));
    end

    // Clear mid-count; load_valid during RUN is ignored; no done pulse
    rstn = 1'b1; clear = 1'b0; en = 1'b1;
    load_valid = 1'b1; load_value = W'(4);
    step();
    check("clr_load", int'(out_w), 4);
    load_valid = 1'b0;
    step();
    load_valid = 1'b1; load_value = W'(9);
    step();
    check("clr_ignore_load", int'(out_w), 2);
    load_valid = 1'b0;
    clear = 1'b1;
    step();
    check("clr_out", int'(out_w), 0);
    check("clr_idle", int'(load_ready), 1);
    check("clr_nodone", int'(done), 0);
    clear = 1'b0;
    step();
    check("clr_nodone_after", int'(done), 0);

    // Clear overrides a simultaneous load
    load_valid = 1'b1; load_value = W'(7); clear = 1'b1;
    step();
    check("clr_vs_load_busy", int'(busy), 0);
    check("clr_vs_load_out", int'(out_w), 0);
    clear = 1'b0; load_valid = 1'b0;

    // Done-count check on a 3-cycle timer in one-shot mode / first period
    load_valid = 1'b1; load_value = W'(3); en = 1'b1;
    step();
    load_valid = 1'b0;
    done_cnt = 0;
    for (int k = 0; k < 3; k++) begin
      step();
      if (done) done_cnt++;
    end
    check("single_done_count", done_cnt, 1);
    check("done_with_out", int'(out_w), PERIODIC ? 3 : 0);
    clear = 1'b1;
    step();
    clear = 1'b0;

    // Randomized run against the model
    for (int k = 0; k < 3000; k++) begin
      rstn       = ($urandom_range(0, 99) != 0);
      clear      = ($urandom_range(0, 39) == 0);
      load_valid = ($urandom_range(0, 3) == 0);
      case ($urandom_range(0, 5))
        0:       load_value = '0;
        1:       load_value = '1;
        2:       load_value = W'(1);
        default: load_value = W'($urandom_range(0, 15));
      endcase
      en = ($urandom_range(0, 3) != 0);
      step();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule : tb_down_counter_timer
